seg_scan_decoder: RTL and testbench

Receive-side counterpart of the hex-to-seven-segment driver. Watches a time-multiplexed, active-low seven-segment bus (segments plus per-digit anodes) and recovers the hex nibble shown on each digit. Only commits a digit after its pattern holds for a configurable number of cycles, which rejects ghosting during anode switchover. Used as the self-check monitor on the display path and as a loopback source for the debug UART.

---
 rtl/seg_pkg.sv | 45 ++++
 rtl/seg_glyph_decode.sv | 35 +++
 rtl/seg_scan_decoder.sv | 138 +++++++++++++
 tb/tb_seg_scan_decoder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: segment bit positions, active-low hex glyphs, monitor FSM states.
// The forward display driver uses the same constants, so both directions agree on every glyph.
package seg_pkg;

  localparam int SEG_A_BIT = 0;
  localparam int SEG_B_BIT = 1;
  localparam int SEG_C_BIT = 2;
  localparam int SEG_D_BIT = 3;
  localparam int SEG_E_BIT = 4;
  localparam int SEG_F_BIT = 5;
  localparam int SEG_G_BIT = 6;

  localparam logic [6:0] M_A = 7'(1 << SEG_A_BIT);
  localparam logic [6:0] M_B = 7'(1 << SEG_B_BIT);
  localparam logic [6:0] M_C = 7'(1 << SEG_C_BIT);
  localparam logic [6:0] M_D = 7'(1 << SEG_D_BIT);
  localparam logic [6:0] M_E = 7'(1 << SEG_E_BIT);
  localparam logic [6:0] M_F = 7'(1 << SEG_F_BIT);
  localparam logic [6:0] M_G = 7'(1 << SEG_G_BIT);

  // Glyphs are the complement of their lit-segment masks (0 = lit).
  localparam logic [6:0] SEG_0 = ~(M_A | M_B | M_C | M_D | M_E | M_F);
  localparam logic [6:0] SEG_1 = ~(M_B | M_C);
  localparam logic [6:0] SEG_2 = ~(M_A | M_B | M_D | M_E | M_G);
  localparam logic [6:0] SEG_3 = ~(M_A | M_B | M_C | M_D | M_G);
  localparam logic [6:0] SEG_4 = ~(M_B | M_C | M_F | M_G);
  localparam logic [6:0] SEG_5 = ~(M_A | M_C | M_D | M_F | M_G);
  localparam logic [6:0] SEG_6 = ~(M_A | M_C | M_D | M_E | M_F | M_G);
  localparam logic [6:0] SEG_7 = ~(M_A | M_B | M_C);
  localparam logic [6:0] SEG_8 = ~(M_A | M_B | M_C | M_D | M_E | M_F | M_G);
  localparam logic [6:0] SEG_9 = ~(M_A | M_B | M_C | M_D | M_F | M_G);
  localparam logic [6:0] SEG_A = ~(M_A | M_B | M_C | M_E | M_F | M_G);
  localparam logic [6:0] SEG_B = ~(M_C | M_D | M_E | M_F | M_G);
  localparam logic [6:0] SEG_C = ~(M_A | M_D | M_E | M_F);
  localparam logic [6:0] SEG_D = ~(M_B | M_C | M_D | M_E | M_G);
  localparam logic [6:0] SEG_E = ~(M_A | M_D | M_E | M_F | M_G);
  localparam logic [6:0] SEG_F = ~(M_A | M_E | M_F | M_G);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HELD
  } state_t;

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational active-low glyph to hex nibble decode; zero latency, no flow control.
// Any pattern outside the sixteen hex glyphs (including all-dark) reports legal_o = 0.
module seg_glyph_decode
  import seg_pkg::*;
(
  input  logic [6:0] seg_n_i,
  output logic [3:0] nibble_o,
  output logic       legal_o
);

  always_comb begin
    nibble_o = 4'h0;
    legal_o  = 1'b1;
    case (seg_n_i)
      SEG_0:   nibble_o = 4'h0;
      SEG_1:   nibble_o = 4'h1;
      SEG_2:   nibble_o = 4'h2;
      SEG_3:   nibble_o = 4'h3;
      SEG_4:   nibble_o = 4'h4;
      SEG_5:   nibble_o = 4'h5;
      SEG_6:   nibble_o = 4'h6;
      SEG_7:   nibble_o = 4'h7;
      SEG_8:   nibble_o = 4'h8;
      SEG_9:   nibble_o = 4'h9;
      SEG_A:   nibble_o = 4'hA;
      SEG_B:   nibble_o = 4'hB;
      SEG_C:   nibble_o = 4'hC;
      SEG_D:   nibble_o = 4'hD;
      SEG_E:   nibble_o = 4'hE;
      SEG_F:   nibble_o = 4'hF;
      default: legal_o  = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers per-digit hex nibbles from a multiplexed active-low 7-seg bus; commits STABLE_CYCLES-1
// edges after a key first appears, outputs registered; pure monitor with no backpressure.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg_n,
  input  logic [DIGITS-1:0]     an_n,
  output logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     digit_valid,
  output logic                  commit,
  output logic                  glyph_err,
  output logic                  anode_err
);

  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_TGT = CW'(STABLE_CYCLES);

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IDXW-1:0]     key_idx_q, key_idx_d;
  logic [6:0]          key_seg_q, key_seg_d;
  logic [4*DIGITS-1:0] value_q, value_d;
  logic [DIGITS-1:0]   valid_q, valid_d;
  logic                commit_q, commit_d;
  logic                glyph_err_q, glyph_err_d;
  logic                anode_err_q, anode_err_d;

  logic [IDXW-1:0]     idx;
  logic [3:0]          low_cnt;
  logic                single;
  logic                multi;
  logic                do_commit;
  logic [3:0]          nibble;
  logic                legal;

  always_comb begin
    idx     = '0;
    low_cnt = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!an_n[i]) begin
        idx     = IDXW'(i);
        low_cnt = low_cnt + 4'd1;
      end
    end
  end

  assign single = (low_cnt == 4'd1);
  assign multi  = (low_cnt >= 4'd2);

  // A commit always concerns the current sample, which equals the key being committed.
  seg_glyph_decode u_glyph (
    .seg_n_i  (seg_n),
    .nibble_o (nibble),
    .legal_o  (legal)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    key_idx_d   = key_idx_q;
    key_seg_d   = key_seg_q;
    do_commit   = 1'b0;
    anode_err_d = 1'b0;
    if (!single) begin
      state_d     = IDLE;
      cnt_d       = '0;
      anode_err_d = multi;
    end else if (state_q == IDLE || idx != key_idx_q || seg_n != key_seg_q) begin
      key_idx_d = idx;
      key_seg_d = seg_n;
      cnt_d     = CW'(1);
      if (STABLE_CYCLES == 1) begin
        do_commit = 1'b1;
        state_d   = HELD;
      end else begin
        state_d = SETTLE;
      end
    end else if (state_q == SETTLE) begin
      cnt_d = cnt_q + CW'(1);
      if (cnt_q + CW'(1) == CNT_TGT) begin
        do_commit = 1'b1;
        state_d   = HELD;
      end
    end
  end

  always_comb begin
    value_d     = value_q;
    valid_d     = valid_q;
    commit_d    = do_commit;
    glyph_err_d = do_commit && !legal;
    if (do_commit) begin
      if (legal) begin
        value_d[4*idx +: 4] = nibble;
        valid_d[idx]        = 1'b1;
      end else begin
        valid_d[idx] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      key_idx_q   <= '0;
      key_seg_q   <= '0;
      value_q     <= '0;
      valid_q     <= '0;
      commit_q    <= 1'b0;
      glyph_err_q <= 1'b0;
      anode_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_idx_q   <= key_idx_d;
      key_seg_q   <= key_seg_d;
      value_q     <= value_d;
      valid_q     <= valid_d;
      commit_q    <= commit_d;
      glyph_err_q <= glyph_err_d;
      anode_err_q <= anode_err_d;
    end
  end

  assign value       = value_q;
  assign digit_valid = valid_q;
  assign commit      = commit_q;
  assign glyph_err   = glyph_err_q;
  assign anode_err   = anode_err_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: run-length reference model compared every cycle,
// plus literal expectations taken from the display test scenarios.
module tb_seg_scan_decoder;

  localparam int SC = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic [15:0] value;
  logic [3:0]  digit_valid;
  logic        commit;
  logic        glyph_err;
  logic        anode_err;

  seg_scan_decoder #(.DIGITS(4), .STABLE_CYCLES(SC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_n       (seg_n),
    .an_n        (an_n),
    .value       (value),
    .digit_valid (digit_valid),
    .commit      (commit),
    .glyph_err   (glyph_err),
    .anode_err   (anode_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int dut_commits = 0;
  bit chk_en = 1'b0;

  // Reference model: outputs follow from run lengths of identical single-anode samples.
  logic [6:0]  glyph [16];
  logic [15:0] m_value;
  logic [3:0]  m_valid;
  logic        m_commit, m_gerr, m_aerr;
  int          run_len;
  int          p_idx;
  logic [6:0]  p_seg;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input string lit);
    logic [6:0] p;
    p = 7'h7f;
    for (int k = 0; k < lit.len(); k++) p[lit[k] - 8'd97] = 1'b0;
    return p;
  endfunction

  task automatic model_reset();
    m_value = '0; m_valid = '0; m_commit = 0; m_gerr = 0; m_aerr = 0;
    run_len = 0; p_idx = 0; p_seg = '0;
  endtask

  task automatic model_step(input logic [6:0] s, input logic [3:0] a);
    int lows, ix, n;
    lows = 0; ix = 0; n = -1;
    for (int i = 0; i < 4; i++) if (!a[i]) begin lows++; ix = i; end
    m_commit = 0; m_gerr = 0; m_aerr = 0;
    if (lows != 1) begin
      run_len = 0;
      m_aerr  = (lows >= 2);
    end else begin
      if (run_len > 0 && ix == p_idx && s == p_seg) run_len++;
      else begin run_len = 1; p_idx = ix; p_seg = s; end
      if (run_len == SC) begin
        m_commit = 1;
        for (int g = 0; g < 16; g++) if (glyph[g] == s) n = g;
        if (n >= 0) begin
          m_value[4*ix +: 4] = 4'(n);
          m_valid[ix] = 1'b1;
        end else begin
          m_valid[ix] = 1'b0;
          m_gerr = 1;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("value", 32'(value), 32'(m_value));
      chk("digit_valid", 32'(digit_valid), 32'(m_valid));
      chk("commit", 32'(commit), 32'(m_commit));
      chk("glyph_err", 32'(glyph_err), 32'(m_gerr));
      chk("anode_err", 32'(anode_err), 32'(m_aerr));
      if (commit) dut_commits++;
    end
  end

  // One sampled cycle: drive, let the edge happen, advance model, settle past the compare.
  task automatic cyc(input logic [6:0] s, input logic [3:0] a);
    seg_n = s;
    an_n  = a;
    @(posedge clk);
    if (rst_n) model_step(s, a);
    @(negedge clk);
    #1;
  endtask

  task automatic run(input logic [6:0] s, input logic [3:0] a, input int n);
    for (int k = 0; k < n; k++) cyc(s, a);
  endtask

  int c0;

  initial begin
    glyph[0]  = seg_of("abcdef");  glyph[1]  = seg_of("bc");
    glyph[2]  = seg_of("abdeg");   glyph[3]  = seg_of("abcdg");
    glyph[4]  = seg_of("bcfg");    glyph[5]  = seg_of("acdfg");
    glyph[6]  = seg_of("acdefg");  glyph[7]  = seg_of("abc");
    glyph[8]  = seg_of("abcdefg"); glyph[9]  = seg_of("abcdfg");
    glyph[10] = seg_of("abcefg");  glyph[11] = seg_of("cdefg");
    glyph[12] = seg_of("adef");    glyph[13] = seg_of("bcdeg");
    glyph[14] = seg_of("adefg");   glyph[15] = seg_of("aefg");
    model_reset();
    rst_n = 1'b0;
    seg_n = 7'h7f;
    an_n  = 4'hf;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    #1;
    chk("reset_value", 32'(value), 32'h0);
    chk("reset_flags", 32'({digit_valid, commit, glyph_err, anode_err}), 32'h0);
    rst_n = 1'b1;
    cyc(7'h7f, 4'hf);

    // Glyph 2 on digit 0: commit lands on the 4th sampled edge.
    c0 = dut_commits;
    run(7'b0100100, 4'b1110, 3);
    chk("t1_no_early_commit", 32'(commit), 32'h0);
    cyc(7'b0100100, 4'b1110);
    chk("t1_commit_pulse", 32'(commit), 32'h1);
    chk("t1_value", 32'(value[3:0]), 32'h2);
    chk("t1_valid", 32'(digit_valid), 32'b0001);
    run(7'b0100100, 4'b1110, 3);
    chk("t1_single_commit", 32'(dut_commits - c0), 32'd1);

    // Glitch of 8 restarts the count; only the final run of 2 commits.
    cyc(7'h7f, 4'hf);
    c0 = dut_commits;
    run(7'b0100100, 4'b1110, 3);
    cyc(7'b0000000, 4'b1110);
    run(7'b0100100, 4'b1110, 4);
    chk("t2_commits", 32'(dut_commits - c0), 32'd1);
    chk("t2_value", 32'(value[3:0]), 32'h2);
    run(7'b0000000, 4'b1110, 4);
    chk("t2_value8", 32'(value[3:0]), 32'h8);

    // Two anodes low for one cycle.
    c0 = dut_commits;
    cyc(7'b0000000, 4'b1100);
    chk("t3_anode_err", 32'(anode_err), 32'h1);
    chk("t3_no_commit", 32'(commit), 32'h0);
    cyc(7'h7f, 4'hf);
    chk("t3_pulse_width", 32'(anode_err), 32'h0);

    // Scan A, b, C, d across digits 0..3.
    c0 = dut_commits;
    run(7'b0001000, 4'b1110, 5);
    run(7'b0000011, 4'b1101, 5);
    run(7'b1000110, 4'b1011, 5);
    run(7'b0100001, 4'b0111, 5);
    chk("t4_value", 32'(value), 32'hDCBA);
    chk("t4_valid", 32'(digit_valid), 32'b1111);
    chk("t4_commits", 32'(dut_commits - c0), 32'd4);

    // Illegal pattern (segment a only) on digit 1.
    run(7'b1111110, 4'b1101, 3);
    cyc(7'b1111110, 4'b1101);
    chk("t5_glyph_err", 32'(glyph_err), 32'h1);
    chk("t5_commit", 32'(commit), 32'h1);
    chk("t5_valid", 32'(digit_valid), 32'b1101);
    chk("t5_value", 32'(value), 32'hDCBA);

    // Reset mid-settle discards the partial count.
    cyc(7'h7f, 4'hf);
    run(7'b0110000, 4'b1011, 3);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_reset_value", 32'(value), 32'h0);
    chk("t6_reset_flags", 32'({digit_valid, commit, glyph_err, anode_err}), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    run(7'b0110000, 4'b1011, 3);
    chk("t6_no_early_commit", 32'(commit), 32'h0);
    cyc(7'b0110000, 4'b1011);
    chk("t6_commit", 32'(commit), 32'h1);
    chk("t6_value", 32'(value), 32'h0300);
    chk("t6_valid", 32'(digit_valid), 32'b0100);

    // Every glyph on digit 3, then all-dark which must be rejected.
    for (int g = 0; g < 16; g++) begin
      cyc(7'h7f, 4'hf);
      run(glyph[g], 4'b0111, SC);
    end
    chk("t7_last_glyph", 32'(value[15:12]), 32'hF);
    cyc(7'h7f, 4'hf);
    run(7'b1111111, 4'b0111, SC);
    chk("t7_dark_err", 32'(glyph_err), 32'h1);
    chk("t7_dark_valid", 32'(digit_valid[3]), 32'h0);
    cyc(7'h7f, 4'hf);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
